// File: rtl/tile_pkg.sv
// Shared geometry constants, lock-state encoding and tile indexing for the
// 2048 tile raster scanner.
package tile_pkg;

    localparam int TILE_PX  = 120;
    localparam int GRID     = 4;
    localparam int BOARD_PX = TILE_PX * GRID;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Tile k = row*4 + col; with GRID=4 this is a plain concatenation.
    function automatic logic [3:0] tile_index(input logic [1:0] trow,
                                              input logic [1:0] tcol);
        return {trow, tcol};
    endfunction

endpackage

// File: rtl/tile_axis_counter.sv
// One raster axis: tracks the pixel offset inside a tile and the tile number,
// restarting at coordinate 0 and freezing once the coordinate leaves the board.
module tile_axis_counter
    import tile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [9:0] coord,
    output logic [6:0] lidx,
    output logic [1:0] tidx
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lidx <= '0;
            tidx <= '0;
        end else if (step) begin
            if (coord == '0) begin
                lidx <= '0;
                tidx <= '0;
            end else if (coord >= 10'(BOARD_PX)) begin
                lidx <= lidx;
                tidx <= tidx;
            end else if (lidx == 7'(TILE_PX - 1)) begin
                lidx <= '0;
                tidx <= tidx + 2'd1;
            end else begin
                lidx <= lidx + 7'd1;
            end
        end
    end

endmodule

// File: rtl/tile_scan_ctrl.sv
// Counter-based pixel-to-tile decoder with raster lock tracking and a
// vblank-gated displayed-board register, two-cycle fixed latency.
module tile_scan_ctrl
    import tile_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [9:0]  col_addr,
    input  logic [8:0]  row_addr,
    input  logic        upd_req,
    input  logic [63:0] upd_board,
    output logic        upd_ack,
    output logic        out_valid,
    output logic [5:0]  area,
    output logic [13:0] addr,
    output logic [3:0]  tile_val,
    output logic        locked,
    output logic        sync_err
);

    lock_state_e state, state_nxt;
    logic        disc, vld_nxt, col_jump, row_jump;
    logic [9:0]  prev_col;
    logic [8:0]  prev_row;
    logic        vblank;
    logic [63:0] disp_board;

    logic        vld_p1, in_board_p1;
    logic [6:0]  lcol_p1, lrow_p1;
    logic [1:0]  tcol_p1, trow_p1;
    logic [3:0]  tidx_p1;

    logic        vld_p2;
    logic [5:0]  area_p2;
    logic [13:0] addr_p2;
    logic [3:0]  tile_val_p2;

    assign col_jump = (col_addr != '0) && (col_addr != prev_col + 10'd1);
    assign row_jump = (row_addr != prev_row) && (row_addr != '0) &&
                      ({1'b0, row_addr} != {1'b0, prev_row} + 10'd1);

    always_comb begin
        state_nxt = state;
        disc      = 1'b0;
        vld_nxt   = 1'b0;
        if (pix_en) begin
            case (state)
                UNLOCKED: begin
                    if (col_addr == '0 && row_addr == '0) begin
                        state_nxt = LOCKED;
                        vld_nxt   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (col_jump || row_jump) begin
                        disc      = 1'b1;
                        state_nxt = UNLOCKED;
                    end else begin
                        vld_nxt = 1'b1;
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            sync_err <= 1'b0;
            prev_col <= '0;
            prev_row <= '0;
            vblank   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_err <= sync_err | disc;
            if (pix_en) begin
                prev_col <= col_addr;
                prev_row <= row_addr;
                vblank   <= (row_addr >= 9'(BOARD_PX));
            end
        end
    end

    // A held request re-arms every cycle, so each vblank cycle with req high loads the board.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_ack    <= 1'b0;
            disp_board <= '0;
        end else begin
            upd_ack <= upd_req & vblank;
            if (upd_req && vblank) disp_board <= upd_board;
        end
    end

    // ---- stage 1: axis counters and board membership ----
    tile_axis_counter u_xcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (pix_en),
        .coord (col_addr),
        .lidx  (lcol_p1),
        .tidx  (tcol_p1)
    );

    tile_axis_counter u_ycnt (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (pix_en && col_addr == '0),
        .coord ({1'b0, row_addr}),
        .lidx  (lrow_p1),
        .tidx  (trow_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            in_board_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_nxt;
            if (pix_en)
                in_board_p1 <= (col_addr < 10'(BOARD_PX)) && (row_addr < 9'(BOARD_PX));
        end
    end

    assign tidx_p1 = tile_index(trow_p1, tcol_p1);

    // ---- stage 2: area, tile-local address and displayed value ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            area_p2     <= '0;
            addr_p2     <= '0;
            tile_val_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                if (in_board_p1) begin
                    area_p2     <= {2'b00, tidx_p1} + 6'd1;
                    addr_p2     <= ({7'b0, lrow_p1} << 7) - ({7'b0, lrow_p1} << 3) + {7'b0, lcol_p1};
                    tile_val_p2 <= disp_board[{tidx_p1, 2'b00} +: 4];
                end else begin
                    area_p2     <= '0;
                    addr_p2     <= '0;
                    tile_val_p2 <= '0;
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign area      = area_p2;
    assign addr      = addr_p2;
    assign tile_val  = tile_val_p2;
    assign locked    = (state == LOCKED);

endmodule

// File: tb/tb_tile_scan_ctrl.sv
// Randomized raster bench for tile_scan_ctrl against an arithmetic reference model.
module tb_tile_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  col_addr = '0;
    logic [8:0]  row_addr = '0;
    logic        upd_req = 1'b0;
    logic [63:0] upd_board = '0;
    logic        upd_ack, out_valid, locked, sync_err;
    logic [5:0]  area;
    logic [13:0] addr;
    logic [3:0]  tile_val;

    always #5 clk = ~clk;

    tile_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .col_addr  (col_addr),
        .row_addr  (row_addr),
        .upd_req   (upd_req),
        .upd_board (upd_board),
        .upd_ack   (upd_ack),
        .out_valid (out_valid),
        .area      (area),
        .addr      (addr),
        .tile_val  (tile_val),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    typedef struct {
        bit vld;
        int area;
        int addr;
        int tval;
        int col;
        int row;
    } exp_t;

    int          n_chk = 0;
    int          n_fail = 0;

    // reference model state
    bit          m_locked, m_err, m_vblank;
    int          m_pcol, m_prow;
    logic [63:0] m_board;
    exp_t        e1, e2;
    bit          a1, l1, s1;
    bit          req_pend = 1'b0;
    logic [63:0] req_board = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_locked = 0; m_err = 0; m_vblank = 0;
        m_pcol = 0; m_prow = 0; m_board = '0;
        e1 = '{default: 0}; e2 = '{default: 0};
        a1 = 0; l1 = 0; s1 = 0;
        req_pend = 0;
    endtask

    // One clock: check what is due now, drive the next inputs, advance the model.
    task automatic cyc(input bit pe, input int col, input int row,
                       input bit force_req, input logic [63:0] force_board);
        bit disc;
        bit ack;
        int tidx;
        @(negedge clk);
        chk("ack", upd_ack, a1);
        chk("locked", locked, l1);
        chk("sync_err", sync_err, s1);
        chk($sformatf("valid(%0d,%0d)", e2.col, e2.row), out_valid, e2.vld);
        if (e2.vld) begin
            chk($sformatf("area(%0d,%0d)", e2.col, e2.row), area, e2.area);
            chk($sformatf("addr(%0d,%0d)", e2.col, e2.row), addr, e2.addr);
            chk($sformatf("tile_val(%0d,%0d)", e2.col, e2.row), tile_val, e2.tval);
        end
        if (a1) req_pend = 0;

        pix_en    = pe;
        col_addr  = 10'(col);
        row_addr  = 9'(row);
        upd_req   = force_req | req_pend;
        upd_board = force_req ? force_board : req_board;

        ack = upd_req && m_vblank;
        if (ack) m_board = upd_board;

        e2 = e1;
        e1 = '{default: 0};
        e1.col = col;
        e1.row = row;
        if (pe) begin
            disc = m_locked && ((col != 0 && col != m_pcol + 1) ||
                                (row != m_prow && row != 0 && row != m_prow + 1));
            if (disc) begin
                m_locked = 0;
                m_err    = 1;
            end else if (!m_locked && col == 0 && row == 0) begin
                m_locked = 1;
            end
            e1.vld = m_locked;
            if (col < 480 && row < 480) begin
                tidx      = (row / 120) * 4 + col / 120;
                e1.area   = tidx + 1;
                e1.addr   = (row % 120) * 120 + col % 120;
                e1.tval   = int'((m_board >> (4 * tidx)) & 64'hF);
            end
            m_pcol   = col;
            m_prow   = row;
            m_vblank = (row >= 480);
        end
        a1 = ack;
        l1 = m_locked;
        s1 = m_err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        pix_en  = 1'b0;
        upd_req = 1'b0;
        @(negedge clk);
        chk("rst upd_ack", upd_ack, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst area", area, 0);
        chk("rst addr", addr, 0);
        chk("rst tile_val", tile_val, 0);
        chk("rst locked", locked, 0);
        chk("rst sync_err", sync_err, 0);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic pix(input int col, input int row, input int gap);
        cyc(1, col, row, 0, '0);
        repeat (gap) cyc(0, col, row, 0, '0);
    endtask

    // Compressed raster: most lines are short, selected lines run past the board edge.
    task automatic frame(input int rst_row, input int jump_row, input int req_row,
                         input int slow_row, input bit dbl,
                         input logic [63:0] b1, input logic [63:0] b2);
        for (int r = 0; r < 482; r++) begin
            int len;
            if (r == 0 || r == 119 || r == 120 || r == 479 || r == slow_row) len = 490;
            else if (r == jump_row) len = 20;
            else len = int'($urandom_range(1, 6));
            if (r == rst_row) do_reset();
            if (r == req_row) req_pend = 1;
            for (int c = 0; c < len; c++) begin
                int cc;
                cc = (r == jump_row && c > 10) ? c + 39 : c;
                pix(cc, r, (r == slow_row) ? 3 : int'($urandom_range(0, 1)));
            end
            if (dbl && r == 481) begin
                cyc(0, 0, r, 1, b1);
                cyc(0, 0, r, 1, b2);
            end
        end
    endtask

    initial begin
        logic [63:0] b1, b2;
        b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        req_board = 64'h0123_4567_89AB_CDEF;
        model_clear();
        do_reset();
        frame(-1, -1, 100, -1, 0, '0, '0);
        frame(-1, -1, -1, 7, 1, b1, b2);
        frame(-1, 5, -1, -1, 0, '0, '0);
        frame(-1, -1, -1, -1, 0, '0, '0);
        frame(200, -1, -1, -1, 0, '0, '0);
        frame(-1, -1, -1, -1, 0, '0, '0);
        repeat (4) cyc(0, 0, 0, 0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
